// File: rtl/bist_sequencer.sv
// Sequencer for the ALU BIST datapath: walks the enabled opcodes, pulses the
// datapath reset before each one, tallies mismatches and reports pass/fail.
module bist_sequencer #(
  parameter int PATTERNS_PER_OP = 16,
  parameter int ERR_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      op_mask,
  input  logic             match,
  output logic             dp_reset,
  output logic [3:0]       alu_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_op,
  output logic [7:0]       first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  localparam logic [7:0] LAST_PAT = 8'(PATTERNS_PER_OP - 1);

  state_t           state_q, state_d;
  logic [15:0]      mask_q, mask_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       pat_q, pat_d;
  logic [ERR_W-1:0] fail_q, fail_d;
  logic             ffv_q, ffv_d;
  logic [3:0]       ffop_q, ffop_d;
  logic [7:0]       ffidx_q, ffidx_d;
  logic [4:0]       first_op, next_op;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Lowest set bit of m at index >= lo; 16 means none.
  function automatic logic [4:0] find_op(input logic [15:0] m, input logic [4:0] lo);
    logic [4:0] r;
    r = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= lo)) r = 5'(i);
    end
    return r;
  endfunction

  assign first_op = find_op(op_mask, 5'd0);
  assign next_op  = find_op(mask_q, {1'b0, op_q} + 5'd1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    op_d    = op_q;
    pat_d   = pat_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffop_d  = ffop_q;
    ffidx_d = ffidx_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mask_d  = op_mask;
            fail_d  = '0;
            ffv_d   = 1'b0;
            ffop_d  = 4'd0;
            ffidx_d = 8'd0;
            pat_d   = 8'd0;
            if (first_op[4]) begin
              state_d = S_DONE;
              op_d    = 4'd0;
            end else begin
              state_d = S_INIT;
              op_d    = first_op[3:0];
            end
          end
        end
        S_INIT: begin
          pat_d   = 8'd0;
          state_d = S_RUN;
        end
        S_RUN: begin
          pat_d = pat_q + 8'd1;
          if (!match) begin
            fail_d = sat_inc(fail_q);
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffop_d  = op_q;
              ffidx_d = pat_q;
            end
          end
          // Last pattern of this opcode: skip straight to the next enabled one.
          if (pat_q == LAST_PAT) begin
            pat_d = 8'd0;
            if (next_op[4]) begin
              state_d = S_DONE;
            end else begin
              state_d = S_INIT;
              op_d    = next_op[3:0];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= 16'd0;
      op_q    <= 4'd0;
      pat_q   <= 8'd0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffop_q  <= 4'd0;
      ffidx_q <= 8'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      pat_q   <= pat_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffop_q  <= ffop_d;
      ffidx_q <= ffidx_d;
    end
  end

  assign dp_reset         = (state_q != S_RUN);
  assign alu_sel          = op_q;
  assign busy             = (state_q == S_INIT) || (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = (state_q == S_DONE) && (fail_q == '0);
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_op    = ffop_q;
  assign first_fail_idx   = ffidx_q;

endmodule
